// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the FP divide arbiter and later FPU blocks.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] FP64_PINF = 64'h7FF0000000000000;
  localparam logic [63:0] FP64_NINF = 64'hFFF0000000000000;

  // Index width for a requester pointer; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter
  import fpdiv_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  // Walk the requesters starting at rr_ptr and pick the first one that is asking.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Shares one multicycle combinational FP64 divider among NUM_REQ requesters.
module fpdiv_arbiter
  import fpdiv_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DIV_CYCLES = 4,
  parameter int TAG_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*64-1:0]    req_a,
  input  logic [NUM_REQ*64-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [63:0]              rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [63:0]              div_a,
  output logic [63:0]              div_b,
  input  logic [63:0]              div_q,
  output logic                     busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   grant_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               rsp_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept   = |(req_valid & req_ready);
  assign rsp_fire = |(rsp_ready & rsp_valid);

  // State register; reset abandons any in-flight divide without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: accept -> hold operands DIV_CYCLES cycles -> wait for the owner to take the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the winner's operands, count down the multicycle window, capture the quotient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_a   <= req_a[64*int'(grant_idx) +: 64];
            div_b   <= req_b[64*int'(grant_idx) +: 64];
            rsp_tag <= req_tag[TAG_W*int'(grant_idx) +: TAG_W];
            owner   <= grant_idx;
            rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            cnt     <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           rsp_result <= div_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: grant only while idle, respond only to the owner, busy outside IDLE.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (state == IDLE) req_ready = grant;
    if (state == RESP) rsp_valid = NUM_REQ'(1) << owner;
  end

endmodule
